// File: rtl/calc_pkg.sv
// Shared calculator types: keypad geometry, scanner state and scan-result enums,
// and the key-code legend used by the core and the display path.
package calc_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HELD,
        ST_RELEASE
    } scan_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_res_t;

    // Key code = row*4 + col on the board legend
    localparam logic [3:0] KEY_1   = 4'h0;
    localparam logic [3:0] KEY_2   = 4'h1;
    localparam logic [3:0] KEY_3   = 4'h2;
    localparam logic [3:0] KEY_ADD = 4'h3;
    localparam logic [3:0] KEY_4   = 4'h4;
    localparam logic [3:0] KEY_5   = 4'h5;
    localparam logic [3:0] KEY_6   = 4'h6;
    localparam logic [3:0] KEY_SUB = 4'h7;
    localparam logic [3:0] KEY_7   = 4'h8;
    localparam logic [3:0] KEY_8   = 4'h9;
    localparam logic [3:0] KEY_9   = 4'hA;
    localparam logic [3:0] KEY_MUL = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_0   = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_DIV = 4'hF;

endpackage

// File: rtl/sync_2ff.sv
// Four-bit two-flop synchronizer for the asynchronous keypad row lines.
module sync_2ff (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives columns one at a time, classifies each full scan,
// debounces press/release and hands one key code per press over valid/ready.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_TICKS     = 2000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_drv,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                overrun
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);

    logic [TW-1:0]       tick;
    logic [1:0]          col_idx;
    logic [NUM_ROWS-1:0] row_sync;
    logic [NUM_ROWS-1:0] row_low;
    logic                sample;
    logic                scan_done;
    logic [2:0]          n_low;
    logic [1:0]          row_hit;
    logic [1:0]          base_count;
    logic [2:0]          sum_count;
    logic [1:0]          new_count;
    logic [3:0]          new_code;
    logic [1:0]          acc_count;
    logic [3:0]          acc_code;
    scan_res_t           scan_res;
    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [CW-1:0]       cnt_inc;
    logic [3:0]          cand;
    logic [3:0]          cand_nxt;
    logic                confirm;
    logic [3:0]          confirm_code;
    logic                transfer;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick    <= '0;
            col_idx <= '0;
        end else if (tick == LAST_TICK) begin
            tick    <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    assign col_drv   = ~(4'b0001 << col_idx);
    assign sample    = (tick == LAST_TICK);
    assign scan_done = sample && (col_idx == 2'd3);

    // Low-row count saturates at 2: anything beyond one hit is already MULTI.
    // Column 0 starts a fresh scan, so the stored totals are ignored there.
    always_comb begin
        row_low = ~row_sync;
        n_low   = '0;
        row_hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_low[r]) begin
                n_low   = n_low + 3'd1;
                row_hit = 2'(r);
            end
        end
        base_count = (col_idx == 2'd0) ? 2'd0 : acc_count;
        sum_count  = {1'b0, base_count} + n_low;
        new_count  = (sum_count >= 3'd2) ? 2'd2 : sum_count[1:0];
        new_code   = (col_idx == 2'd0) ? 4'd0 : acc_code;
        if (base_count == 2'd0 && n_low == 3'd1) begin
            new_code = {row_hit, col_idx};
        end
        case (new_count)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_SINGLE;
            default: scan_res = RES_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_count <= '0;
            acc_code  <= '0;
        end else if (sample) begin
            acc_count <= new_count;
            acc_code  <= new_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cand_nxt     = cand;
        confirm      = 1'b0;
        confirm_code = cand;
        cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        if (scan_done) begin
            case (state)
                ST_IDLE: begin
                    if (scan_res == RES_SINGLE) begin
                        cand_nxt  = new_code;
                        cnt_nxt   = CW'(1);
                        state_nxt = ST_PRESS;
                        if (DEBOUNCE_SCANS == 1) begin
                            confirm      = 1'b1;
                            confirm_code = new_code;
                            state_nxt    = ST_HELD;
                        end
                    end
                end
                ST_PRESS: begin
                    if (scan_res == RES_SINGLE && new_code == cand) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            confirm   = 1'b1;
                            state_nxt = ST_HELD;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (scan_res != RES_SINGLE) begin
                        cnt_nxt   = CW'(1);
                        state_nxt = ST_RELEASE;
                        if (DEBOUNCE_SCANS == 1) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scan_res == RES_NONE) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        state_nxt = ST_HELD;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign transfer = key_valid && key_ready;

    // A confirm landing on a transfer cycle reloads the slot instead of overrunning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (confirm) begin
            if (!key_valid || transfer) begin
                key_code  <= confirm_code;
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (transfer) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a scan-level keypad/debounce reference model checks
// every cycle, a per-scan vector table covers the named scenarios, then random scans.
module tb_keypad_scanner;

    localparam int TICKS     = 4;
    localparam int DEB       = 2;
    localparam int SCAN_CYC  = 4 * TICKS;

    logic        clk;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_drv;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        overrun;

    logic [15:0] pressed;

    int errors;
    int checks;
    int valid_seen;

    int          m_n;
    bit          m_valid;
    logic [3:0]  m_code;
    bit          m_ovr;
    bit          m_armed;
    int          m_run;
    logic [3:0]  m_run_code;

    typedef struct {
        logic [15:0] keys;
        int          rdy;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl [34];

    keypad_scanner #(
        .SCAN_TICKS     (TICKS),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_drv   (col_drv),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col_drv[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_n);
        end
    endtask

    task automatic model_reset();
        m_n        = 0;
        m_valid    = 0;
        m_code     = 4'h0;
        m_ovr      = 0;
        m_armed    = 1;
        m_run      = 0;
        m_run_code = 4'h0;
    endtask

    // Whole-scan view: count pressed keys, then track press/release runs.
    task automatic model_scan(output bit conf, output logic [3:0] ccode);
        int  n;
        bit  single;
        bit  none;
        logic [3:0] c;
        n = $countones(pressed);
        single = (n == 1);
        none = (n == 0);
        c = 4'h0;
        for (int k = 0; k < 16; k++) if (pressed[k]) c = 4'(k);
        conf  = 0;
        ccode = 4'h0;
        if (m_armed) begin
            if (m_run == 0) begin
                if (single) begin
                    m_run = 1;
                    m_run_code = c;
                end
            end else if (single && c == m_run_code) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= DEB) begin
                conf    = 1;
                ccode   = m_run_code;
                m_armed = 0;
                m_run   = 0;
            end
        end else begin
            if (m_run == 0) begin
                if (!single) m_run = 1;
            end else if (none) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= DEB) begin
                m_armed = 1;
                m_run   = 0;
            end
        end
    endtask

    task automatic apply_stimulus(input bit rdy);
        bit         transfer;
        bit         conf;
        logic [3:0] cc;
        logic [3:0] exp_col;
        key_ready = rdy;
        @(posedge clk);
        transfer = m_valid && rdy;
        conf = 0;
        cc = 4'h0;
        if (m_n % SCAN_CYC == SCAN_CYC - 1) model_scan(conf, cc);
        if (conf) begin
            if (!m_valid || transfer) begin
                m_code  = cc;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (transfer) begin
            m_valid = 0;
        end
        m_n++;
        #1;
        exp_col = ~(4'b0001 << ((m_n / TICKS) % 4));
        check_output("col_drv", col_drv, exp_col);
        check_output("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check_output("key_code", key_code, m_code);
        check_output("overrun", {3'b0, overrun}, {3'b0, m_ovr});
        if (key_valid) valid_seen++;
    endtask

    // Ready modes: 0 low, 1 high, 2 high on the scan's last cycle only, 3 random.
    task automatic run_scan(input logic [15:0] keys, input int mode);
        bit rdy;
        pressed = keys;
        for (int i = 0; i < SCAN_CYC; i++) begin
            case (mode)
                0:       rdy = 0;
                1:       rdy = 1;
                2:       rdy = (i == SCAN_CYC - 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            apply_stimulus(rdy);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        valid_seen = 0;
        pressed    = '0;
        key_ready  = 1'b0;
        rst        = 1'b1;
        model_reset();

        tbl[0]  = '{16'h0200, 1, 1'b0, 4'h0, 1'b0};
        tbl[1]  = '{16'h0200, 1, 1'b1, 4'h9, 1'b0};
        tbl[2]  = '{16'h0200, 1, 1'b0, 4'h9, 1'b0};
        tbl[3]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b0};
        tbl[4]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b0};
        tbl[5]  = '{16'h0008, 1, 1'b0, 4'h9, 1'b0};
        tbl[6]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b0};
        tbl[7]  = '{16'h0000, 1, 1'b0, 4'h9, 1'b0};
        tbl[8]  = '{16'h0021, 1, 1'b0, 4'h9, 1'b0};
        tbl[9]  = '{16'h0021, 1, 1'b0, 4'h9, 1'b0};
        tbl[10] = '{16'h0001, 1, 1'b0, 4'h9, 1'b0};
        tbl[11] = '{16'h0001, 1, 1'b1, 4'h0, 1'b0};
        tbl[12] = '{16'h0000, 1, 1'b0, 4'h0, 1'b0};
        tbl[13] = '{16'h0000, 1, 1'b0, 4'h0, 1'b0};
        tbl[14] = '{16'h0008, 0, 1'b0, 4'h0, 1'b0};
        tbl[15] = '{16'h0008, 0, 1'b1, 4'h3, 1'b0};
        tbl[16] = '{16'h0000, 0, 1'b1, 4'h3, 1'b0};
        tbl[17] = '{16'h0000, 0, 1'b1, 4'h3, 1'b0};
        tbl[18] = '{16'h0040, 0, 1'b1, 4'h3, 1'b0};
        tbl[19] = '{16'h0040, 2, 1'b1, 4'h6, 1'b0};
        tbl[20] = '{16'h0000, 1, 1'b0, 4'h6, 1'b0};
        tbl[21] = '{16'h0000, 1, 1'b0, 4'h6, 1'b0};
        tbl[22] = '{16'h0040, 1, 1'b0, 4'h6, 1'b0};
        tbl[23] = '{16'h0040, 1, 1'b1, 4'h6, 1'b0};
        tbl[24] = '{16'h0000, 1, 1'b0, 4'h6, 1'b0};
        tbl[25] = '{16'h0000, 1, 1'b0, 4'h6, 1'b0};
        tbl[26] = '{16'h0008, 0, 1'b0, 4'h6, 1'b0};
        tbl[27] = '{16'h0008, 0, 1'b1, 4'h3, 1'b0};
        tbl[28] = '{16'h0000, 0, 1'b1, 4'h3, 1'b0};
        tbl[29] = '{16'h0000, 0, 1'b1, 4'h3, 1'b0};
        tbl[30] = '{16'h1000, 0, 1'b1, 4'h3, 1'b0};
        tbl[31] = '{16'h1000, 0, 1'b1, 4'h3, 1'b1};
        tbl[32] = '{16'h0000, 1, 1'b0, 4'h3, 1'b1};
        tbl[33] = '{16'h0000, 1, 1'b0, 4'h3, 1'b1};

        #1 rst = 1'b0;
        #2;
        check_output("reset_col_drv", col_drv, 4'b1110);
        check_output("reset_key_valid", {3'b0, key_valid}, 4'h0);
        check_output("reset_key_code", key_code, 4'h0);
        check_output("reset_overrun", {3'b0, overrun}, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();

        for (int v = 0; v < 34; v++) begin
            run_scan(tbl[v].keys, tbl[v].rdy);
            check_output($sformatf("tbl%0d_valid", v), {3'b0, key_valid}, {3'b0, tbl[v].exp_valid});
            check_output($sformatf("tbl%0d_code", v), key_code, tbl[v].exp_code);
            check_output($sformatf("tbl%0d_overrun", v), {3'b0, overrun}, {3'b0, tbl[v].exp_ovr});
        end

        // Long hold: exactly one valid cycle, no auto-repeat.
        valid_seen = 0;
        for (int s = 0; s < 50; s++) run_scan(16'h0200, 1);
        check_output("hold_valid_cycles", 4'(valid_seen), 4'd1);
        run_scan(16'h0000, 1);
        run_scan(16'h0000, 1);

        // Asynchronous reset at column 2, tick 2 while a key is pending.
        run_scan(16'h0020, 0);
        run_scan(16'h0020, 0);
        check_output("pre_reset_valid", {3'b0, key_valid}, 4'h1);
        pressed = '0;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
        #2 rst = 1'b0;
        #1;
        check_output("async_col_drv", col_drv, 4'b1110);
        check_output("async_key_valid", {3'b0, key_valid}, 4'h0);
        check_output("async_overrun", {3'b0, overrun}, 4'h0);
        check_output("async_key_code", key_code, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        run_scan(16'h0000, 1);

        for (int it = 0; it < 30; it++) begin
            logic [15:0] keys;
            int kind;
            int hold;
            kind = $urandom_range(0, 3);
            keys = '0;
            if (kind == 1 || kind == 2) begin
                keys[$urandom_range(0, 15)] = 1'b1;
            end else if (kind == 3) begin
                keys[$urandom_range(0, 15)] = 1'b1;
                keys[$urandom_range(0, 15)] = 1'b1;
            end
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) run_scan(keys, 3);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
